key_matrix_scan: RTL and testbench
==================================

// Module: key_matrix_scan
// PURPOSE
//  Input-side counterpart of the multiplexed LED scan driver. Drives one-hot column strobes into a
//  ROWSxCOLS key matrix and samples the row returns. It debounces each key and emits press/release
//  events over a valid/ready handshake to game-control logic. Key index = col*ROWS + row, the same
//  slot layout as the LED display word.
// PARAMETERS
//  SCAN_INTERVAL   100_000  cycles-1 per column slot; slot = SCAN_INTERVAL+1 cycles; legal >= 3
//  ROWS            4        row inputs per column
//  COLS            4        column strobes
//  DEBOUNCE_SCANS  4        consecutive identical samples (1/frame) needed to change a key state; >= 1
// PORTS
//  clk        in   1                clock
//  rst        in   1                reset, asynchronous, active-high
//  key_col    out  COLS             one-hot column strobe, active-high
//  key_row    in   ROWS             raw row returns, asynchronous, active-high = pressed
//  keys       out  ROWS*COLS        debounced key state, bit k = key k
//  evt_valid  out  1                event available
//  evt_ready  in   1                consumer accepts event
//  evt_code   out  KW               key index; KW = $clog2(ROWS*COLS)
//  evt_press  out  1                1 = press, 0 = release
//  evt_lost   out  1                1-cycle pulse: edge merged into an already-pending key
// BEHAVIOUR
//  Reset: key_col = 'b1 (column 0), keys = 0, evt_valid = 0, evt_code = 0, evt_press = 0,
//    evt_lost = 0, slot counter = 0, all debounce counters and the pending mask = 0.
//  Slot counter: counts 0..SCAN_INTERVAL. At ==SCAN_INTERVAL it returns to 0 and col advances,
//    wrapping COLS-1 -> 0. key_col is registered and always one-hot.
//  key_row goes through a 2-flop synchronizer. Sample point = the cycle where counter==SCAN_INTERVAL,
//    before the column changes. The ROWS sampled bits belong to the current col.
//  Debounce, per key, at its column's sample point:
//    - sample == keys[k]: count cleared.
//    - sample differs: count++. When count reaches DEBOUNCE_SCANS, keys[k] toggles and count clears.
//    - keys[k] updates the cycle after the sample point.
//  Pending mask: on a debounced edge of key k, pend[k] is set. If pend[k] is already set,
//    evt_lost pulses for 1 cycle and the edge is merged.
//  Emitter (registered outputs):
//    - When evt_valid==0 and pend != 0, load the lowest set index on the next cycle:
//      evt_code = index, evt_press = keys[index] at load time. Clear pend[index] on load.
//    - evt_valid, evt_code and evt_press hold stable until evt_valid && evt_ready.
//    - evt_valid drops the cycle after the handshake. The next load follows at the earliest 1 cycle later.
//  Simultaneous load and new edge on the same key: the edge re-sets pend (not lost).
//  evt_ready is ignored while evt_valid==0.
//  Reset mid-frame or mid-handshake: immediate return to reset values. Pending events are discarded.
// CONFIGURATION
//  KEY_RELEASE_EVT_EN defined: both rising and falling debounced edges set pend; evt_press reflects state.
//  Undefined: only rising edges set pend; evt_press is constant 1; keys still tracks releases.
// STRUCTURE
//  Package key_scan_pkg holds:
//    - KW computation function
//    - MIN_SCAN_INTERVAL = 3
//    - typedef key_evt_t {code, press}
//  Sub-module key_debounce (one per key, generate loop): inputs sample, sample_en; output state;
//    parameter DEBOUNCE_SCANS.
//  Top holds the slot counter, column ring, synchronizer, pending mask and priority emitter.
// TESTING (SCAN_INTERVAL=3, ROWS=COLS=4, DEBOUNCE_SCANS=2; slot=4, frame=16 cycles)
//  Reset released -> key_col=0001. It advances 0010,0100,1000,0001 every 4 cycles.
//    keys=0, evt_valid=0.
//  Hold key_row[1]=1 only while col 2 is driven, 2 frames -> keys[9]=1 after the 2nd sample.
//    Then evt_valid=1, evt_code=9, evt_press=1.
//  1-frame glitch on key 5 -> keys unchanged, no event, evt_valid stays 0.
//  Keys 3 and 12 pressed together, evt_ready=0 -> event code 3 is held for 20 cycles.
//    Raise ready -> code 3 accepted, then code 12 follows with a 1-cycle gap.
//  Key 9 pressed then released while evt_ready=0 and event 9 is not yet loaded -> evt_lost pulses once.
//    A single event is delivered; evt_press=0 with KEY_RELEASE_EVT_EN, evt_press=1 without.
//  Assert rst mid-handshake with evt_valid=1 -> same cycle: evt_valid=0, key_col=0001, keys=0.
//    No stale event after release.

Source files
------------

// File: rtl/key_scan_pkg.sv
// rtl/key_scan_pkg.sv - shared constants, width helper and event type for the key matrix scanner
package key_scan_pkg;

  // Smallest legal SCAN_INTERVAL: the 2-flop synchronizer needs time to settle after a column change
  localparam int MIN_SCAN_INTERVAL = 3;

  // Widest key index the event type can carry (up to 256 keys)
  localparam int MAX_KW = 8;

  // Bits needed to encode n distinct values, never less than 1
  function automatic int calc_kw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [MAX_KW-1:0] code;
    logic              press;
  } key_evt_t;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - per-key debouncer, one sample per scan frame
module key_debounce
  import key_scan_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sample,
  input  logic sample_en,
  output logic state
);

  localparam int CW = calc_kw(DEBOUNCE_SCANS + 1);

  logic          r_state;
  logic [CW-1:0] r_count;

  // Count consecutive disagreeing samples; toggle the debounced state once enough have been seen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= 1'b0;
      r_count <= '0;
    end else if (sample_en) begin
      if (sample == r_state) begin
        r_count <= '0;
      end else if (r_count == CW'(DEBOUNCE_SCANS - 1)) begin
        r_state <= ~r_state;
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign state = r_state;

endmodule

// File: rtl/key_matrix_scan.sv
// rtl/key_matrix_scan.sv - key matrix column scanner with debounce and event emitter (KEY_RELEASE_EVT_EN adds release events)
module key_matrix_scan
  import key_scan_pkg::*;
#(
  parameter int SCAN_INTERVAL  = 100_000,
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int DEBOUNCE_SCANS = 4,
  localparam int KW            = calc_kw(ROWS * COLS)
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [COLS-1:0]      key_col,
  input  logic [ROWS-1:0]      key_row,
  output logic [ROWS*COLS-1:0] keys,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [KW-1:0]        evt_code,
  output logic                 evt_press,
  output logic                 evt_lost
);

  localparam int NK = ROWS * COLS;
  localparam int SW = calc_kw(SCAN_INTERVAL + 1);

  if (SCAN_INTERVAL < MIN_SCAN_INTERVAL) begin : g_bad_interval
    $error("key_matrix_scan: SCAN_INTERVAL below minimum");
  end

  logic [SW-1:0]   r_slot;
  logic [COLS-1:0] r_col;
  logic [ROWS-1:0] r_sync1;
  logic [ROWS-1:0] r_sync2;
  logic [NK-1:0]   r_keys_prev;
  logic [NK-1:0]   r_pend;
  logic            r_evt_valid;
  key_evt_t        r_evt;
  logic            r_lost;

  logic            w_sample_pt;
  logic [NK-1:0]   w_keys;
  logic [NK-1:0]   w_set;
  logic            w_load;
  logic [KW-1:0]   w_load_idx;
  logic [NK-1:0]   w_load_mask;
  logic            w_lost;

  assign w_sample_pt = (r_slot == SW'(SCAN_INTERVAL));

  // Slot counter: one column slot is SCAN_INTERVAL+1 cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot <= '0;
    end else if (w_sample_pt) begin
      r_slot <= '0;
    end else begin
      r_slot <= r_slot + 1'b1;
    end
  end

  // One-hot column ring, advanced only after the current column has been sampled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= COLS'(1);
    end else if (w_sample_pt) begin
      r_col <= (r_col << 1) | (r_col >> (COLS - 1));
    end
  end

  // Two-flop synchronizer for the asynchronous row returns
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= key_row;
      r_sync2 <= r_sync1;
    end
  end

  // Key k lives in column k/ROWS, row k%ROWS; it is sampled only while its column is strobed
  for (genvar k = 0; k < NK; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_deb (
      .clk      (clk),
      .rst      (rst),
      .sample   (r_sync2[k % ROWS]),
      .sample_en(w_sample_pt & r_col[k / ROWS]),
      .state    (w_keys[k])
    );
  end

  // Previous debounced state, used to find debounced edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_keys_prev <= '0;
    end else begin
      r_keys_prev <= w_keys;
    end
  end

  // Edge selection, lowest-index priority pick and merge detection
  always_comb begin
`ifdef KEY_RELEASE_EVT_EN
    w_set = w_keys ^ r_keys_prev;
`else
    w_set = w_keys & ~r_keys_prev;
`endif
    w_load     = ~r_evt_valid & (|r_pend);
    w_load_idx = '0;
    for (int i = NK - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_load_idx = KW'(i);
      end
    end
    w_load_mask = w_load ? (NK'(1) << w_load_idx) : '0;
    // A key just being loaded is free again, so a simultaneous edge re-arms it instead of merging
    w_lost = |(w_set & r_pend & ~w_load_mask);
  end

  // Pending mask and the one-cycle merge pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      r_lost <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~w_load_mask) | w_set;
      r_lost <= w_lost;
    end
  end

  // Event register: load when idle, hold until accepted, then stay idle for at least one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_evt_valid <= 1'b0;
      r_evt       <= '0;
    end else if (r_evt_valid && evt_ready) begin
      r_evt_valid <= 1'b0;
    end else if (w_load) begin
      r_evt_valid <= 1'b1;
      r_evt.code  <= MAX_KW'(w_load_idx);
`ifdef KEY_RELEASE_EVT_EN
      r_evt.press <= w_keys[w_load_idx];
`else
      r_evt.press <= 1'b1;
`endif
    end
  end

  assign key_col   = r_col;
  assign keys      = w_keys;
  assign evt_valid = r_evt_valid;
  assign evt_code  = KW'(r_evt.code);
  assign evt_press = r_evt.press;
  assign evt_lost  = r_lost;

endmodule

// File: tb/tb_key_matrix_scan.sv
// tb/tb_key_matrix_scan.sv - directed self-checking bench for key_matrix_scan (honours KEY_RELEASE_EVT_EN)
module tb_key_matrix_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key_col;
  logic [3:0]  key_row;
  logic [15:0] keys;
  logic        evt_valid;
  logic        evt_ready;
  logic [3:0]  evt_code;
  logic        evt_press;
  logic        evt_lost;

  logic [15:0] pressed;
  int          cyc;
  int          checks   = 0;
  int          failures = 0;

`ifdef KEY_RELEASE_EVT_EN
  localparam int L         = 253;
  localparam bit EXP_PRESS = 1'b0;
`else
  localparam int L         = 285;
  localparam bit EXP_PRESS = 1'b1;
`endif

  key_matrix_scan #(
    .SCAN_INTERVAL (3),
    .ROWS          (4),
    .COLS          (4),
    .DEBOUNCE_SCANS(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_col  (key_col),
    .key_row  (key_row),
    .keys     (keys),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_code (evt_code),
    .evt_press(evt_press),
    .evt_lost (evt_lost)
  );

  always #5 clk = ~clk;

  // Matrix model: a pressed key shorts its column strobe onto its row return
  always_comb begin
    key_row = '0;
    for (int c = 0; c < 4; c++) begin
      if (key_col[c]) key_row = key_row | pressed[c*4 +: 4];
    end
  end

  // Posedges since reset release
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic goto(input int p);
    while (cyc < p) @(negedge clk);
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    evt_ready = 1'b0;
    pressed   = '0;
    repeat (3) @(negedge clk);
    check("rst_col", key_col, 4'b0001);
    check("rst_keys", keys, 16'h0);
    check("rst_valid", evt_valid, 1'b0);
    check("rst_code", evt_code, 4'd0);
    check("rst_press", evt_press, 1'b0);
    check("rst_lost", evt_lost, 1'b0);
    rst = 1'b0;

    goto(3);  check("col_p3", key_col, 4'b0001);
    goto(4);  check("col_p4", key_col, 4'b0010);
    goto(8);  check("col_p8", key_col, 4'b0100);
    goto(12); check("col_p12", key_col, 4'b1000);
    goto(16); check("col_p16", key_col, 4'b0001);
    check("idle_keys", keys, 16'h0);
    check("idle_valid", evt_valid, 1'b0);
    pressed[9] = 1'b1;

    goto(43); check("k9_before", keys, 16'h0000);
    goto(44); check("k9_after", keys, 16'h0200);
    goto(45); check("k9_valid_lat", evt_valid, 1'b0);
    goto(46);
    check("k9_valid", evt_valid, 1'b1);
    check("k9_code", evt_code, 4'd9);
    check("k9_press", evt_press, 1'b1);
    evt_ready = 1'b1;
    goto(47); check("k9_accepted", evt_valid, 1'b0);
    pressed[9] = 1'b0;
    goto(77); check("k9_released", keys, 16'h0000);

    goto(80); pressed[5] = 1'b1;
    goto(88); pressed[5] = 1'b0;
    goto(130);
    check("glitch_keys", keys, 16'h0000);
    check("glitch_valid", evt_valid, 1'b0);
    evt_ready = 1'b0;

    goto(144); pressed[3] = 1'b1; pressed[12] = 1'b1;
    goto(165); check("k3_valid_lat", evt_valid, 1'b0);
    goto(166);
    check("k3_valid", evt_valid, 1'b1);
    check("k3_code", evt_code, 4'd3);
    check("k3_press", evt_press, 1'b1);
    goto(186);
    check("k3_hold_valid", evt_valid, 1'b1);
    check("k3_hold_code", evt_code, 4'd3);
    check("k3_k12_keys", keys, 16'h1008);
    evt_ready = 1'b1;
    goto(187); check("k3_gap", evt_valid, 1'b0);
    evt_ready = 1'b0;
    goto(188);
    check("k12_valid", evt_valid, 1'b1);
    check("k12_code", evt_code, 4'd12);
    check("k12_press", evt_press, 1'b1);
    pressed[9] = 1'b1;
    goto(221); pressed[9] = 1'b0;
`ifndef KEY_RELEASE_EVT_EN
    goto(253); pressed[9] = 1'b1;
`endif
    goto(L - 1); check("lost_before", evt_lost, 1'b0);
    goto(L);     check("lost_pulse", evt_lost, 1'b1);
    goto(L + 1);
    check("lost_after", evt_lost, 1'b0);
    check("k12_held_code", evt_code, 4'd12);
    evt_ready = 1'b1;
    goto(L + 2); check("k12_accepted", evt_valid, 1'b0);
    goto(L + 3);
    check("merged_valid", evt_valid, 1'b1);
    check("merged_code", evt_code, 4'd9);
    check("merged_press", evt_press, EXP_PRESS);
    goto(L + 4); check("merged_accepted", evt_valid, 1'b0);
    evt_ready = 1'b0;
    goto(L + 8);
    check("single_event", evt_valid, 1'b0);
    check("no_extra_lost", evt_lost, 1'b0);
    pressed[0] = 1'b1;

    n = 0;
    while (!evt_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("k0_valid_wait", evt_valid, 1'b1);
    check("k0_code", evt_code, 4'd0);
    rst = 1'b1;
    #1;
    check("midrst_valid", evt_valid, 1'b0);
    check("midrst_col", key_col, 4'b0001);
    check("midrst_keys", keys, 16'h0000);
    pressed = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    goto(40);
    check("post_rst_valid", evt_valid, 1'b0);
    check("post_rst_keys", keys, 16'h0000);
    check("post_rst_lost", evt_lost, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
